// File: rtl/vga_sched_pkg.sv
// Shared types and defaults for the vertical-blank update scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {ACTIVE, ARB, GRANT, CLOSED} state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 64;
  localparam int DEF_FCNT_W    = 16;

  // OR-reduction of set-bit positions; exact for one-hot or all-zero input.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vblank_update_scheduler_if.sv
// Request/grant and frame-status bundle between display writers and the vblank scheduler.
interface vblank_update_scheduler_if #(
  parameter int N_REQ  = vga_sched_pkg::DEF_N_REQ,
  parameter int FCNT_W = vga_sched_pkg::DEF_FCNT_W
);
  logic              vblnk;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  done;
  logic [N_REQ-1:0]  grant;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_cnt;
  logic              revoked;
  logic [7:0]        missed_cnt;

  modport master (
    output vblnk, req, done,
    input  grant, frame_start, frame_cnt, revoked, missed_cnt
  );

  modport slave (
    input  vblnk, req, done,
    output grant, frame_start, frame_cnt, revoked, missed_cnt
  );
endinterface

// File: rtl/rr_select.sv
// Rotate-priority picker: first set bit of eligible at or above ptr, wrapping.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic [IDX_W-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr) + off) % N_REQ);
      if (eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Round-robin grant of the vertical-blank window to display-state writers, plus frame pulse/counter.
// Optional missed-frame statistics are built when VBLANK_SCHED_STATS_EN is defined.
module vblank_update_scheduler
  import vga_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int FCNT_W    = DEF_FCNT_W
) (
  input logic                      clk,
  input logic                      rst,
  vblank_update_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int BW    = $clog2(MAX_BURST + 1);

  state_t            state;
  logic              vblnk_d;
  logic [N_REQ-1:0]  served;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  eligible;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [BW-1:0]     burst_cnt;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              frame_start_q;
  logic              revoked_q;
  logic              rise;
  logic              fall;
  logic              done_g;
  logic              budget_end;

  assign rise       = bus.vblnk & ~vblnk_d;
  assign fall       = ~bus.vblnk & vblnk_d;
  assign eligible   = bus.req & ~served;
  assign g_idx      = IDX_W'(onehot_to_idx(8'(grant_q)));
  assign next_ptr   = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
  assign done_g     = bus.done[g_idx];
  assign budget_end = (burst_cnt == BW'(MAX_BURST - 1));

  rr_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_select (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // NOTE: all state here is updated with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ACTIVE;
      vblnk_d       <= 1'b0;
      served        <= '0;
      grant_q       <= '0;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      revoked_q     <= 1'b0;
    end else begin
      vblnk_d       <= bus.vblnk;
      frame_start_q <= rise;
      revoked_q     <= 1'b0;
      if (rise) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);

      // A rise always opens a fresh frame, including a glitch outside ACTIVE.
      if (rise) begin
        served    <= '0;
        grant_q   <= '0;
        revoked_q <= (state == GRANT);
        state     <= ARB;
      end else begin
        case (state)
          ACTIVE: grant_q <= '0;
          ARB: begin
            if (!bus.vblnk) begin
              state <= ACTIVE;
            end else if (pick_valid) begin
              grant_q   <= N_REQ'(1) << pick_idx;
              burst_cnt <= '0;
              state     <= GRANT;
            end else begin
              state <= CLOSED;
            end
          end
          GRANT: begin
            burst_cnt <= burst_cnt + BW'(1);
            if (fall) begin
              grant_q <= '0;
              state   <= ACTIVE;
              if (done_g) begin
                served[g_idx] <= 1'b1;
                rr_ptr        <= next_ptr;
              end else begin
                revoked_q <= 1'b1;
              end
            end else if (done_g || budget_end) begin
              grant_q       <= '0;
              served[g_idx] <= 1'b1;
              rr_ptr        <= next_ptr;
              revoked_q     <= ~done_g;
              state         <= ARB;
            end
          end
          CLOSED: begin
            if (fall)           state <= ACTIVE;
            else if (|eligible) state <= ARB;
          end
          default: state <= ACTIVE;
        endcase
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.revoked     = revoked_q;

`ifdef VBLANK_SCHED_STATS_EN
  logic [7:0] missed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missed_q <= '0;
    end else if (fall && (|eligible) && (missed_q != 8'hFF)) begin
      missed_q <= missed_q + 8'd1;
    end
  end

  assign bus.missed_cnt = missed_q;
`else
  assign bus.missed_cnt = '0;
`endif

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: cycle table for arbitration plus hand sequences.
module tb_vblank_update_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vblank_update_scheduler_if #(.N_REQ(4), .FCNT_W(2)) bus ();

  vblank_update_scheduler #(.N_REQ(4), .MAX_BURST(64), .FCNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef VBLANK_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       vblnk;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       revoked;
    logic       frame_start;
    logic [1:0] frame_cnt;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t v(input logic vb, input logic [3:0] rq, input logic [3:0] dn,
                             input logic [3:0] gr, input logic rv, input logic fs,
                             input logic [1:0] fc);
    vec_t r;
    r.vblnk = vb; r.req = rq; r.done = dn;
    r.grant = gr; r.revoked = rv; r.frame_start = fs; r.frame_cnt = fc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs for one cycle; outputs are sampled 1 ns after the edge that captured them.
  task automatic step(input logic vb, input logic [3:0] rq, input logic [3:0] dn);
    bus.vblnk = vb;
    bus.req   = rq;
    bus.done  = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    bus.vblnk = 1'b0;
    bus.req   = '0;
    bus.done  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int fs_seen;
    int n_hi;
    int rev_seen;
    logic [1:0] exp_fc;

    rst       = 1'b0;
    bus.vblnk = 1'b0;
    bus.req   = '0;
    bus.done  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset grant", 32'(bus.grant), 0);
    check("reset frame_start", 32'(bus.frame_start), 0);
    check("reset frame_cnt", 32'(bus.frame_cnt), 0);
    check("reset revoked", 32'(bus.revoked), 0);
    check("reset missed_cnt", 32'(bus.missed_cnt), 0);
    rst = 1'b1;

    // Reset asserted mid-grant drops outputs immediately.
    step(0, 4'b1111, 0);
    step(1, 4'b1111, 0);
    check("pre-reset frame_start", 32'(bus.frame_start), 1);
    step(1, 4'b1111, 0);
    check("pre-reset grant", 32'(bus.grant), 32'b0001);
    check("pre-reset frame_cnt", 32'(bus.frame_cnt), 1);
    #3 rst = 1'b0;
    #1;
    check("async reset grant", 32'(bus.grant), 0);
    check("async reset frame_cnt", 32'(bus.frame_cnt), 0);
    bus.vblnk = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    fs_seen = 0;
    repeat (3) begin
      step(0, 4'b1111, 0);
      fs_seen += int'(bus.frame_start);
    end
    check("no frame_start before rise", 32'(fs_seen), 0);
    step(1, 4'b1111, 0);
    check("post-reset rise frame_start", 32'(bus.frame_start), 1);
    check("post-reset rise frame_cnt", 32'(bus.frame_cnt), 1);
    step(1, 4'b1111, 0);
    check("post-reset frame_start single", 32'(bus.frame_start), 0);
    check("rise-to-grant latency", 32'(bus.grant), 32'b0001);
    do_reset();

    // Round-robin over 1011, ignored done/req drop, CLOSED, pointer wrap, window-end revoke.
    tbl[0]  = v(0, 4'b1011, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[1]  = v(1, 4'b1011, 4'b0000, 4'b0000, 0, 1, 1);
    tbl[2]  = v(1, 4'b1011, 4'b0000, 4'b0001, 0, 0, 1);
    tbl[3]  = v(1, 4'b1011, 4'b0000, 4'b0001, 0, 0, 1);
    tbl[4]  = v(1, 4'b1011, 4'b0010, 4'b0001, 0, 0, 1);
    tbl[5]  = v(1, 4'b1011, 4'b0000, 4'b0001, 0, 0, 1);
    tbl[6]  = v(1, 4'b1011, 4'b0000, 4'b0001, 0, 0, 1);
    tbl[7]  = v(1, 4'b1011, 4'b0001, 4'b0000, 0, 0, 1);
    tbl[8]  = v(1, 4'b1011, 4'b0000, 4'b0010, 0, 0, 1);
    tbl[9]  = v(1, 4'b1011, 4'b0000, 4'b0010, 0, 0, 1);
    tbl[10] = v(1, 4'b1001, 4'b0000, 4'b0010, 0, 0, 1);
    tbl[11] = v(1, 4'b1011, 4'b0000, 4'b0010, 0, 0, 1);
    tbl[12] = v(1, 4'b1011, 4'b0000, 4'b0010, 0, 0, 1);
    tbl[13] = v(1, 4'b1011, 4'b0010, 4'b0000, 0, 0, 1);
    tbl[14] = v(1, 4'b1011, 4'b0000, 4'b1000, 0, 0, 1);
    tbl[15] = v(1, 4'b1011, 4'b0000, 4'b1000, 0, 0, 1);
    tbl[16] = v(1, 4'b1011, 4'b0000, 4'b1000, 0, 0, 1);
    tbl[17] = v(1, 4'b1011, 4'b0000, 4'b1000, 0, 0, 1);
    tbl[18] = v(1, 4'b1011, 4'b0000, 4'b1000, 0, 0, 1);
    tbl[19] = v(1, 4'b1011, 4'b1000, 4'b0000, 0, 0, 1);
    tbl[20] = v(1, 4'b1011, 4'b0000, 4'b0000, 0, 0, 1);
    tbl[21] = v(1, 4'b1011, 4'b0000, 4'b0000, 0, 0, 1);
    tbl[22] = v(0, 4'b1011, 4'b0000, 4'b0000, 0, 0, 1);
    tbl[23] = v(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1);
    tbl[24] = v(1, 4'b1111, 4'b0000, 4'b0000, 0, 1, 2);
    tbl[25] = v(1, 4'b1111, 4'b0000, 4'b0001, 0, 0, 2);
    tbl[26] = v(1, 4'b1111, 4'b0001, 4'b0000, 0, 0, 2);
    tbl[27] = v(1, 4'b1111, 4'b0000, 4'b0010, 0, 0, 2);
    tbl[28] = v(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 2);
    tbl[29] = v(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 2);
    tbl[30] = v(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 2);

    for (int i = 0; i < 31; i++) begin
      step(tbl[i].vblnk, tbl[i].req, tbl[i].done);
      check($sformatf("row%0d grant", i), 32'(bus.grant), 32'(tbl[i].grant));
      check($sformatf("row%0d revoked", i), 32'(bus.revoked), 32'(tbl[i].revoked));
      check($sformatf("row%0d frame_start", i), 32'(bus.frame_start), 32'(tbl[i].frame_start));
      check($sformatf("row%0d frame_cnt", i), 32'(bus.frame_cnt), 32'(tbl[i].frame_cnt));
    end

    // Budget: pointer is 1, so req[2] wins first and never answers.
    step(1, 4'b0101, 0);
    check("budget frame_cnt", 32'(bus.frame_cnt), 3);
    step(1, 4'b0101, 0);
    check("budget first grant", 32'(bus.grant), 32'b0100);
    n_hi     = 1;
    rev_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 4'b0101, 0);
      rev_seen += int'(bus.revoked);
      if (bus.grant == 4'b0100) n_hi++;
      else break;
    end
    check("budget grant length", 32'(n_hi), 64);
    check("budget grant dropped", 32'(bus.grant), 0);
    check("budget revoked pulses", 32'(rev_seen), 1);
    step(1, 4'b0101, 0);
    check("budget next grant", 32'(bus.grant), 32'b0001);
    check("budget revoked single", 32'(bus.revoked), 0);
    step(1, 4'b0101, 4'b0001);
    check("budget done ends grant", 32'(bus.grant), 0);
    step(1, 4'b0101, 0);
    step(0, 4'b0101, 0);
    check("budget closed no grant", 32'(bus.grant), 0);

    // Frame counter wrap with a 2-bit counter starting from 3.
    exp_fc = 2'd3;
    for (int f = 0; f < 5; f++) begin
      fs_seen = 0;
      repeat (3) begin
        step(0, 0, 0);
        fs_seen += int'(bus.frame_start);
      end
      step(1, 0, 0);
      fs_seen += int'(bus.frame_start);
      exp_fc = exp_fc + 2'd1;
      check($sformatf("frame%0d frame_cnt", f), 32'(bus.frame_cnt), 32'(exp_fc));
      repeat (2) begin
        step(1, 0, 0);
        fs_seen += int'(bus.frame_start);
      end
      check($sformatf("frame%0d frame_start count", f), 32'(fs_seen), 1);
    end

    // Stats: req[3] during a one-cycle vblank is never served.
    do_reset();
    for (int f = 1; f <= 260; f++) begin
      step(1, 4'b1000, 0);
      step(0, 4'b1000, 0);
      step(0, 4'b1000, 0);
      if (f <= 3 || f == 255 || f == 260)
        check($sformatf("missed_cnt frame%0d", f), 32'(bus.missed_cnt),
              STATS ? 32'((f > 255) ? 255 : f) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
